mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle integer multiply/divide unit for the MIPS datapath. It performs mult, multu, div and divu, which the 32-bit combinational ALU does not implement.
- The datapath control issues a request with a one-cycle start pulse. The unit stalls the pipeline via busy, then writes the HI/LO result registers and pulses done.
- Sits beside the ALU. It takes the same first/second operands and writes HI/LO, which mfhi/mflo read.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  00=mult, 01=multu, 10=div, 11=divu; captured with start.
- first  input  WIDTH  multiplicand / dividend; captured with start.
- second  input  WIDTH  multiplier / divisor; captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; hi/lo are valid from this cycle.
- hi  output  WIDTH  mult: upper product word; div: remainder.
- lo  output  WIDTH  mult: lower product word; div: quotient.
- div_zero  output  1  set with done when a div/divu had second==0; cleared on the next accepted start.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; internal accumulators cleared. Asserting reset mid-operation aborts it, and no done is produced.
- States:
  - IDLE -> RUN on start.
  - RUN -> RUN while the iteration count is below ITER.
  - RUN -> FIX after ITER iterations.
  - FIX -> IDLE.
- Timing:
  - start high at edge E in IDLE: operands/op are latched, busy=1 after E.
  - Edges E+1..E+32 each perform one iteration.
  - Edge E+33 (FIX): sign correction, hi/lo written, done=1, busy=0.
  - done is high for exactly one cycle. Fixed latency: 33 cycles from accept to done.
- start while busy (RUN/FIX) is ignored. Operand or op changes after accept have no effect.
- start in the same cycle that done is high (state IDLE at that edge) is accepted normally. hi/lo hold until the next FIX.
- Multiply: shift-add on operand magnitudes, one multiplier bit per iteration, 64-bit product. For mult, magnitudes are taken first, and the product is negated in FIX if the operand signs differ. multu uses raw operands.
- Divide: restoring division on magnitudes, one quotient bit per iteration. For div:
  - quotient is negated if the operand signs differ;
  - remainder takes the sign of the dividend.
  - divu uses raw operands.
- div/divu with second==0: the full latency is still used. Result hi=first (unchanged), lo=all ones, div_zero=1.
- div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is wrap-around and is not flagged.
- mult/multu never sets div_zero.
- hi/lo change only at FIX or reset.

Optional Feature:
- Macro: MUL_DIV_EARLY_EN.
- Defined: in RUN with op mult/multu, if the remaining (shifted) multiplier magnitude register is zero at an edge, that edge transitions to FIX instead of iterating. For second==0 this means done at E+2. Divide latency is unchanged.
- Undefined: multiply always takes 33 cycles; no early-exit logic is present.

Test Plan:
- Reset check: reset_n=0 -> busy=0, done=0, hi=0, lo=0, div_zero=0.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
- mult -7 (0xFFFFFFF9) x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu 100 / 0 -> hi=100, lo=0xFFFFFFFF, div_zero=1. A subsequent divu 100/7 gives lo=14, hi=2, div_zero=0.
- Protocol/reset: start pulsed again during RUN -> ignored, only one done. reset_n low at cycle 10 of a divide -> no done, outputs return to 0. With MUL_DIV_EARLY_EN defined, mult 5 x 0 -> done at E+2, hi=lo=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle mult/multu/div/divu unit writing HI/LO; fixed 33-cycle latency.
// Optional MUL_DIV_EARLY_EN: multiply exits to FIX once the multiplier runs out.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   first_q;
    logic               neg_q, rsign_q, dz_q;
    logic [2*WIDTH-1:0] acc, sh;
    logic [WIDTH-1:0]   q;
    logic [CW-1:0]      cnt;

    logic               early, s1, s2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;

    // acc: product (mult) or partial remainder (div); q: multiplier or dividend/quotient
    always_comb begin
        s1   = ~op[0] & first[WIDTH-1];
        s2   = ~op[0] & second[WIDTH-1];
        mag1 = s1 ? -first : first;
        mag2 = s2 ? -second : second;
        diff = {acc[WIDTH-1:0], q[WIDTH-1]} - {1'b0, sh[WIDTH-1:0]};
        prod = neg_q ? -acc : acc;
    end

`ifdef MUL_DIV_EARLY_EN
    assign early = ~op_q[1] & (q == '0);
`else
    assign early = 1'b0;
`endif

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (early || cnt == CW'(ITER - 1)) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            first_q  <= '0;
            neg_q    <= 1'b0;
            rsign_q  <= 1'b0;
            dz_q     <= 1'b0;
            acc      <= '0;
            sh       <= '0;
            q        <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        first_q  <= first;
                        neg_q    <= s1 ^ s2;
                        rsign_q  <= s1;
                        dz_q     <= op[1] & (second == '0);
                        acc      <= '0;
                        cnt      <= '0;
                        div_zero <= 1'b0;
                        sh       <= {{WIDTH{1'b0}}, (op[1] ? mag2 : mag1)};
                        q        <= op[1] ? mag1 : mag2;
                    end
                end
                RUN: begin
                    if (!early) begin
                        cnt <= cnt + 1'b1;
                        if (!op_q[1]) begin
                            if (q[0]) acc <= acc + sh;
                            sh <= sh << 1;
                            q  <= q >> 1;
                        end else if (!diff[WIDTH]) begin
                            acc <= {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                            q   <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= {{WIDTH{1'b0}}, acc[WIDTH-2:0], q[WIDTH-1]};
                            q   <= {q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (!op_q[1]) begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi       <= first_q;
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        lo <= neg_q ? -q : q;
                        hi <= rsign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, monitor pops on done.
// Latency model follows MUL_DIV_EARLY_EN when the bench is built with it.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] first = '0;
    logic [W-1:0] second = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    mul_div_unit #(.WIDTH(W), .ITER(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .first    (first),
        .second   (second),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   npass = 0;
    int   ntot  = 0;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    // cycles from the issuing negedge to the negedge where done is seen
    function automatic int lat(input logic [1:0] o, input logic [W-1:0] b);
        int n;
        logic [W-1:0] m;
        n = 34;
        m = b;
`ifdef MUL_DIV_EARLY_EN
        if (!o[1]) begin
            if (!o[0] && b[W-1]) m = -b;
            n = 3;
            while (m != 0) begin
                m = m >> 1;
                n++;
            end
            if (n > 34) n = 34;
        end
`else
        if (o[1] && m[0]) n = 34;
`endif
        return n;
    endfunction

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                ntot++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
                chk({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
                chk({mon_e.name, "_dz"}, 64'(div_zero), 64'(mon_e.dz));
                chk({mon_e.name, "_lat"}, 64'(cyc), 64'(mon_e.due));
                chk({mon_e.name, "_busy"}, 64'(busy), 64'(0));
            end
        end
    end

    task automatic issue(input string n, input logic [1:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic dz);
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            ntot++;
            $display("FAIL %s_idle_timeout: busy=%0b required 0", n, busy);
        end
        start  = 1'b1;
        op     = o;
        first  = a;
        second = b;
        sb.push_back('{eh, el, dz, cyc + lat(o, b), n});
        @(negedge clk);
        start  = 1'b0;
        op     = ~o;
        first  = ~a;
        second = ~b;
    endtask

    task automatic drain(input string n);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            ntot++;
            $display("FAIL %s_drain_timeout: pending=%0d required 0", n, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        issue("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001, 1'b0);
        issue("mult_neg", 2'b00, 32'hFFFFFFF9, 32'd3,
              32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        issue("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        issue("divu_zero", 2'b11, 32'd100, 32'd0,
              32'd100, 32'hFFFFFFFF, 1'b1);
        issue("divu_7", 2'b11, 32'd100, 32'd7,
              32'd2, 32'd14, 1'b0);
        issue("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
              32'h00000000, 32'h80000000, 1'b0);
        issue("div_zero_s", 2'b10, 32'hFFFFFF00, 32'd0,
              32'hFFFFFF00, 32'hFFFFFFFF, 1'b1);
        issue("mult_x0", 2'b00, 32'd5, 32'd0,
              32'd0, 32'd0, 1'b0);
        drain("seq");

        issue("mult_ign", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        repeat (5) @(negedge clk);
        start  = 1'b1;
        op     = 2'b11;
        first  = 32'd1;
        second = 32'd0;
        @(negedge clk);
        start  = 1'b0;
        drain("ignore");
        repeat (40) @(negedge clk);

        issue("div_abort", 2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        chk("abort_dz", 64'(div_zero), 64'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_idle", 64'(busy), 64'(0));
        chk("abort_lo_hold", 64'(lo), 64'(0));

        issue("mult_negneg", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'd0, 32'd1, 1'b0);
        issue("multu_2", 2'b01, 32'hFFFFFFFF, 32'd2,
              32'd1, 32'hFFFFFFFE, 1'b0);
        drain("tail");
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
